pipelined_imem: RTL and testbench

PIPELINED_IMEM -- requirements
Module: pipelined_imem

---
 rtl/imem_pkg.sv | 11 +
 rtl/imem_rsp_fifo.sv | 53 +++++
 rtl/pipelined_imem.sv | 117 +++++++++++
 tb/tb_pipelined_imem.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants for the pipelined instruction memory.
package imem_pkg;
   localparam int DATA_W_DEF  = 32;
   localparam int ADDR_W_DEF  = 32;
   localparam int DEPTH_DEF   = 128;
   localparam int LATENCY_DEF = 1;
   localparam int LAT_MAX     = 4;
   localparam int INIT_INDEX  = 0;
   localparam int INIT_ZERO   = 1;
   localparam int CNT_W       = $clog2(LAT_MAX + 1);
endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous response FIFO; holds results the consumer stalls on.
module imem_rsp_fifo #(
   parameter int W     = 33,
   parameter int DEPTH = 1
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SZ = 1 << PW;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [SZ];
   logic [PW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic          do_push, do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_q];

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= nxt(wr_q);
         if (do_pop)  rd_q <= nxt(rd_q);
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end
endmodule

// File: rtl/pipelined_imem.sv
// Instruction memory with a fixed-latency read pipe, response FIFO
// and a program-load write port.
module pipelined_imem
   import imem_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int LATENCY   = LATENCY_DEF,
   parameter int INIT_MODE = INIT_INDEX
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Req_valid,
   output logic              Req_ready,
   input  logic [ADDR_W-1:0] Req_addr,
   output logic              Rsp_valid,
   input  logic              Rsp_ready,
   output logic [DATA_W-1:0] Rsp_instr,
   output logic              Rsp_err,
   input  logic              Load_en,
   input  logic [ADDR_W-1:0] Load_addr,
   input  logic [DATA_W-1:0] Load_data
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int FW    = DATA_W + 1;

   typedef logic [DATA_W-1:0] mem_t [DEPTH];

   function automatic mem_t init_mem();
      mem_t m;
      for (int i = 0; i < DEPTH; i++)
         m[i] = (INIT_MODE == INIT_ZERO) ? '0 : DATA_W'(4 * i);
      return m;
   endfunction

   mem_t mem_q = init_mem();

   logic [LATENCY-1:0] pv_q;
   logic               pe_q [LATENCY];
   logic [DATA_W-1:0]  pd_q [LATENCY];
   logic [CNT_W-1:0]   count_q, count_d;

   logic             acc, rsp_pop, req_bad, ld_bad;
   logic [IDX_W-1:0] req_idx, ld_idx;
   logic             f_push, f_pop, f_full, f_empty;
   logic [FW-1:0]    f_rdata, tail, sel;

   assign req_idx = Req_addr[IDX_W+1:2];
   assign ld_idx  = Load_addr[IDX_W+1:2];
   assign req_bad = (Req_addr[1:0] != 2'b00) ||
                    ((Req_addr >> (IDX_W + 2)) != '0);
   assign ld_bad  = (Load_addr[1:0] != 2'b00) ||
                    ((Load_addr >> (IDX_W + 2)) != '0);

   assign rsp_pop   = Rsp_valid && Rsp_ready;
   assign Req_ready = ((count_q < CNT_W'(LATENCY)) || rsp_pop) &&
                      !Load_en && Reset_n;
   assign acc       = Req_valid && Req_ready;

   always_ff @(posedge Clk) begin
      if (Load_en && !ld_bad) mem_q[ld_idx] <= Load_data;
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         pv_q <= '0;
      end else begin
         pv_q[0] <= acc;
         for (int i = 1; i < LATENCY; i++) pv_q[i] <= pv_q[i-1];
      end
   end

   // Data lanes carry no reset; only the valid bits qualify them.
   always_ff @(posedge Clk) begin
      pe_q[0] <= req_bad;
      pd_q[0] <= req_bad ? '0 : mem_q[req_idx];
      for (int i = 1; i < LATENCY; i++) begin
         pe_q[i] <= pe_q[i-1];
         pd_q[i] <= pd_q[i-1];
      end
   end

   assign tail    = {pe_q[LATENCY-1], pd_q[LATENCY-1]};
   assign f_push  = pv_q[LATENCY-1] && !f_full && !(f_empty && Rsp_ready);
   assign f_pop   = !f_empty && Rsp_ready;

   imem_rsp_fifo #(.W(FW), .DEPTH(LATENCY)) u_fifo (
      .clk_i   (Clk),
      .rst_n_i (Reset_n),
      .push_i  (f_push),
      .pop_i   (f_pop),
      .wdata_i (tail),
      .rdata_o (f_rdata),
      .full_o  (f_full),
      .empty_o (f_empty)
   );

   assign sel       = f_empty ? tail : f_rdata;
   assign Rsp_valid = !f_empty || pv_q[LATENCY-1];
   assign Rsp_instr = Rsp_valid ? sel[DATA_W-1:0] : '0;
   assign Rsp_err   = Rsp_valid && sel[DATA_W];

   always_comb begin
      count_d = count_q;
      unique case ({acc, rsp_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) count_q <= '0;
      else          count_q <= count_d;
   end
endmodule

// File: tb/tb_pipelined_imem.sv
// Randomised and directed bench for pipelined_imem against a queue model.
module tb_pipelined_imem;
   localparam int L     = 3;
   localparam int DEPTH = 128;

   logic        Clk = 0, Reset_n = 0;
   logic        Req_valid = 0, Rsp_ready = 1, Load_en = 0;
   logic [31:0] Req_addr = 0, Load_addr = 0, Load_data = 0;
   logic        Req_ready, Rsp_valid, Rsp_err;
   logic [31:0] Rsp_instr;

   pipelined_imem #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH),
                    .LATENCY(L), .INIT_MODE(0)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .Req_valid(Req_valid), .Req_ready(Req_ready), .Req_addr(Req_addr),
      .Rsp_valid(Rsp_valid), .Rsp_ready(Rsp_ready),
      .Rsp_instr(Rsp_instr), .Rsp_err(Rsp_err),
      .Load_en(Load_en), .Load_addr(Load_addr), .Load_data(Load_data)
   );

   always #5 Clk = ~Clk;

   typedef struct { logic [31:0] d; logic e; int due; } exp_t;
   typedef struct { logic [31:0] d; logic e; int cyc; } got_t;

   exp_t        exp_q[$];
   got_t        log_q[$];
   logic [31:0] mm [DEPTH];
   int          cyc = 0, checks = 0, errors = 0, n_acc = 0;
   bit          post_rst = 0;

   initial for (int i = 0; i < DEPTH; i++) mm[i] = 32'(4 * i);

   function automatic bit bad(input logic [31:0] a);
      return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, req, cyc);
      end
   endtask

   task automatic chk_log(input string nm, input int i,
                          input logic [31:0] d, input logic e);
      if (i >= log_q.size()) begin
         checks++;
         errors++;
         $display("FAIL %s: response %0d missing, got %0d responses",
                  nm, i, log_q.size());
      end else begin
         chk({nm, "_data"}, log_q[i].d, d);
         chk({nm, "_err"}, 32'(log_q[i].e), 32'(e));
      end
   endtask

   // Model: each accepted request is visible L cycles after its accept cycle
   always @(negedge Clk) begin
      bit ev, er, acc, pop;
      ev = exp_q.size() > 0 && exp_q[0].due <= cyc;
      er = (exp_q.size() < L || (ev && Rsp_ready)) && !Load_en && Reset_n;
      chk("req_ready", 32'(Req_ready), 32'(er));
      chk("rsp_valid", 32'(Rsp_valid), 32'(ev));
      if (ev) begin
         chk("rsp_instr", Rsp_instr, exp_q[0].d);
         chk("rsp_err", 32'(Rsp_err), 32'(exp_q[0].e));
      end
      if (post_rst) begin
         chk("rst_instr", Rsp_instr, 0);
         chk("rst_err", 32'(Rsp_err), 0);
         post_rst = 0;
      end
      acc = Req_valid && er;
      pop = ev && Rsp_ready;
      if (!Reset_n) begin
         exp_q.delete();
         post_rst = 1;
      end else begin
         if (pop) begin
            log_q.push_back('{Rsp_instr, Rsp_err, cyc});
            void'(exp_q.pop_front());
         end
         if (acc) begin
            n_acc++;
            exp_q.push_back('{bad(Req_addr) ? 32'h0 : mm[Req_addr[8:2]],
                              bad(Req_addr), cyc + L});
         end
         if (Load_en && !bad(Load_addr)) mm[Load_addr[8:2]] = Load_data;
      end
      cyc++;
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic drain();
      Req_valid = 0;
      Load_en   = 0;
      Rsp_ready = 1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
      chk("drain_timeout", exp_q.size(), 0);
      step();
   endtask

   function automatic logic [31:0] rnd_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) return 32'($urandom_range(0, DEPTH - 1) * 4);
      if (r < 9) return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      return 32'h200 + 32'($urandom_range(0, 1023));
   endfunction

   initial begin
      int c0, n0;
      logic [31:0] s1e [3];
      s1e = '{32'h0, 32'h4, 32'h1FC};
      step();
      step();
      Reset_n = 1;
      step();

      // back-to-back reads
      log_q.delete();
      Req_valid = 1;
      Req_addr  = 32'h0;
      c0 = cyc;
      step();
      Req_addr = 32'h4;
      step();
      Req_addr = 32'h1FC;
      step();
      drain();
      chk("s1_count", log_q.size(), 3);
      for (int i = 0; i < 3; i++) begin
         chk_log("s1", i, s1e[i], 0);
         if (i < log_q.size()) chk("s1_cycle", log_q[i].cyc, c0 + L + i);
      end

      // misaligned and out-of-range
      log_q.delete();
      Req_valid = 1;
      Req_addr  = 32'h2;
      c0 = cyc;
      step();
      Req_addr = 32'h200;
      step();
      drain();
      chk_log("s2a", 0, 0, 1);
      chk_log("s2b", 1, 0, 1);
      if (log_q.size() == 2) begin
         chk("s2_lat_a", log_q[0].cyc, c0 + 3);
         chk("s2_lat_b", log_q[1].cyc, c0 + 4);
      end

      // consumer stall caps outstanding at L
      log_q.delete();
      Rsp_ready = 0;
      Req_valid = 1;
      n0 = n_acc;
      for (int i = 0; i < 5; i++) begin
         Req_addr = 32'h20 + 32'(4 * i);
         step();
      end
      chk("s3_accepts", n_acc - n0, 3);
      chk("s3_ready_low", 32'(Req_ready), 0);
      drain();
      chk_log("s3_0", 0, 32'h20, 0);
      chk_log("s3_1", 1, 32'h24, 0);
      chk_log("s3_2", 2, 32'h28, 0);
      chk("s3_resume", 32'(Req_ready), 1);

      // load vs in-flight read
      log_q.delete();
      Req_valid = 1;
      Req_addr  = 32'h10;
      step();
      Req_valid = 0;
      Load_en   = 1;
      Load_addr = 32'h10;
      Load_data = 32'hDEADBEEF;
      step();
      Load_en   = 0;
      Req_valid = 1;
      step();
      drain();
      chk_log("s4_old", 0, 32'h10, 0);
      chk_log("s4_new", 1, 32'hDEADBEEF, 0);

      // reset with requests in flight
      log_q.delete();
      Req_valid = 1;
      Req_addr  = 32'h10;
      step();
      Req_addr = 32'h14;
      step();
      Req_valid = 0;
      Reset_n   = 0;
      step();
      Reset_n = 1;
      for (int i = 0; i < 6; i++) step();
      chk("s5_no_rsp", log_q.size(), 0);
      chk("s5_ready", 32'(Req_ready), 1);
      Req_valid = 1;
      Req_addr  = 32'h10;
      step();
      drain();
      chk_log("s5_mem", 0, 32'hDEADBEEF, 0);

      // load blocks requests; misaligned load dropped
      log_q.delete();
      Req_valid = 1;
      Req_addr  = 32'h30;
      Load_en   = 1;
      Load_addr = 32'h40;
      Load_data = 32'h12345678;
      n0 = n_acc;
      step();
      Load_addr = 32'h41;
      Load_data = 32'hBAD0BAD0;
      step();
      chk("s6_blocked", n_acc - n0, 0);
      Load_en = 0;
      step();
      chk("s6_accept", n_acc - n0, 1);
      Req_addr = 32'h40;
      step();
      drain();
      chk_log("s6_req", 0, 32'h30, 0);
      chk_log("s6_load", 1, 32'h12345678, 0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         Req_valid = ($urandom_range(0, 3) != 0);
         Req_addr  = rnd_addr();
         Rsp_ready = ($urandom_range(0, 3) != 0);
         Load_en   = ($urandom_range(0, 15) == 0);
         Load_addr = rnd_addr();
         Load_data = $urandom;
         Reset_n   = ($urandom_range(0, 99) != 0);
         step();
      end
      Reset_n = 1;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
